conv_frame_ctrl: RTL and testbench
==================================

# conv_frame_ctrl

Frame-level sequencer for the first-layer convolution path: line buffer `fifo_image_input`, then `conv2d` (3×3, 16 output channels, hard-swish). It loads the 432 weights and 16 biases from a word stream into a parameter bank, meters RGB pixels into the line buffer, and gates line-buffer windows down to stride-2 positions. It then counts `conv2d` results and signals frame completion. One frame per `start`; it replaces testbench-driven `wr_en` and free-running `start_flag`.

## Interface
- `BITSIZE`, 18: fixed-point word width.
- `IMAGE_SIZE`, 224: input width and height in pixels.
- `STRIDE`, 2: convolution stride.
- `NUM_W`, 432: number of weight words (16 filters × 27).
- `NUM_B`, 16: number of bias words.
- `FLUSH_PIXELS`, 225: zero pixels pushed after the last real pixel (IMAGE_SIZE+1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins a frame; honoured only in IDLE.
- `reuse_params` in 1: sampled with `start`; 1 skips the parameter load.
- `param_valid` in 1, `param_ready` out 1, `param_data` in BITSIZE: parameter word stream.
- `pix_valid` in 1, `pix_ready` out 1: upstream pixel handshake. Pixel data bypasses this block.
- `fifo_wr_en` out 1: line-buffer write enable.
- `pix_zero` out 1: high during flush; the pixel mux then selects 0.
- `win_valid` in 1: `data_valid` from the line buffer.
- `conv_start` out 1: drives `conv2d.start_flag`.
- `hs_valid` in 1: result strobe from `conv2d`.
- `weights` out BITSIZE*NUM_W; `bias` out BITSIZE*NUM_B: parameter bank outputs, flat buses.
- `busy` out 1, `done` out 1, `err` out 1 (sticky).

## Operation
- FSM: IDLE → LOAD → STREAM → FLUSH → DRAIN → DONE → IDLE.
- **IDLE:** `start`=1 moves to LOAD, or to STREAM if `reuse_params`=1. All frame counters clear on this transition.
- **LOAD:** `param_ready`=1. Each accepted word k (0..447) is written as follows:
  - k < NUM_W: `weights[k*BITSIZE +: BITSIZE]`.
  - otherwise: `bias[(k-NUM_W)*BITSIZE +: BITSIZE]`.
  - After word 447 is accepted, go to STREAM.
- **STREAM:**
  - `pix_ready`=1.
  - `fifo_wr_en = pix_valid & pix_ready`.
  - After IMAGE_SIZE² accepted pixels, `pix_ready` drops and the FSM goes to FLUSH.
- **FLUSH:** `fifo_wr_en`=1 and `pix_zero`=1 for exactly FLUSH_PIXELS cycles, then go to DRAIN.
- **Window gating (STREAM/FLUSH/DRAIN):**
  - Counters `wrow`, `wcol` run 0..IMAGE_SIZE-1 and advance in raster order on each `win_valid`.
  - `conv_start = win_valid & (wrow % STRIDE == 0) & (wcol % STRIDE == 0)`, combinational.
  - `win_valid` after IMAGE_SIZE² windows is ignored and sets `err`.
- **Result counting:** `hs_valid` increments `out_cnt`. When `out_cnt` reaches OUT_SIZE² (OUT_SIZE = IMAGE_SIZE/STRIDE), go to DONE. This check is made in any active state.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- `busy` = (state ≠ IDLE).
- `hs_valid` while IDLE sets `err`. `err` clears only on `rst`.
- `start` outside IDLE is ignored.
- `weights`/`bias` hold their contents across frames; only LOAD or `rst` changes them.

## Timing
- **Reset values:** state IDLE; all counters 0; `weights`, `bias` = 0. `param_ready`, `pix_ready`, `fifo_wr_en`, `pix_zero`, `conv_start`, `busy`, `done`, `err` = 0.
- `rst` asserted mid-frame: the next cycle matches the reset values. In-flight words are dropped and the bank is zeroed.
- `start` high at edge t gives `busy`=1 and `param_ready`=1 (or `pix_ready`=1) in cycle t+1.
- `param_ready` and `pix_ready` are registered (state-decoded). A handshake completes at an edge where valid & ready are both 1.
- `param_valid` gaps stall LOAD indefinitely. `pix_valid` gaps insert `fifo_wr_en`=0 bubbles.
- Last-pixel edge → FLUSH in the next cycle. FLUSH occupies exactly FLUSH_PIXELS cycles.
- `conv_start` has zero added latency versus `win_valid`.
- The edge that accepts the final `hs_valid` → `done`=1 in the next cycle; `busy` remains 1 in that cycle.
- `hs_valid` and `win_valid` in the same cycle are both counted.

## Structure
- **Package `conv_ctrl_pkg`:**
  - state enum: IDLE, LOAD, STREAM, FLUSH, DRAIN, DONE.
  - derived localparams: OUT_SIZE, NUM_PIX = IMAGE_SIZE², NUM_OUT = OUT_SIZE², NUM_PARAMS = NUM_W + NUM_B.
  - counter widths via `$clog2`.
- **Sub-module `param_bank`:** addressed register bank with write strobe, address, and data. It exposes the flat `weights`/`bias` buses and is zeroed on reset.
- The FSM, pixel/flush counters, window counters, and output counter stay in the top.

## Test plan
- Reset, then idle 5 cycles → every output 0. `start` with `param_valid`=0 → `busy`=1, `param_ready`=1, state held in LOAD.
- Stream words k=0..447 with value k+1 and random valid gaps → `weights` word 0 = 1, word 431 = 432, `bias` word 15 = 448. STREAM entered after the last word.
- IMAGE_SIZE=8, `reuse_params`=1, ideal line-buffer model (64 windows) → exactly 16 `conv_start`, at (row,col) ∈ {0,2,4,6}². 16 `hs_valid` → `done` pulse one cycle after the 16th.
- `pix_valid` toggling 50% → `fifo_wr_en` count = 64 real + 9 flush (IMAGE_SIZE=8), and `pix_zero` is high only for the 9 flush cycles.
- `start` during STREAM → ignored, counters unchanged. `rst` on pixel 30 → all outputs 0 next cycle, and a fresh frame then completes correctly.
- `hs_valid` in IDLE, or a 65th `win_valid` (IMAGE_SIZE=8) → `err`=1 and it stays set until `rst`.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the first-layer convolution frame sequencer.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_BITSIZE    = 18;
    localparam int unsigned DEF_IMAGE_SIZE = 224;
    localparam int unsigned DEF_STRIDE     = 2;
    localparam int unsigned DEF_NUM_W      = 432;
    localparam int unsigned DEF_NUM_B      = 16;
    localparam int unsigned DEF_FLUSH      = DEF_IMAGE_SIZE + 1;

    localparam int unsigned OUT_SIZE   = DEF_IMAGE_SIZE / DEF_STRIDE;
    localparam int unsigned NUM_PIX    = DEF_IMAGE_SIZE * DEF_IMAGE_SIZE;
    localparam int unsigned NUM_OUT    = OUT_SIZE * OUT_SIZE;
    localparam int unsigned NUM_PARAMS = DEF_NUM_W + DEF_NUM_B;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_frame_ctrl_param_bank.sv
// Addressed weight/bias register bank exposed as flat buses; words below NUM_W are weights.
module param_bank #(
    parameter int unsigned BITSIZE = 18,
    parameter int unsigned NUM_W   = 432,
    parameter int unsigned NUM_B   = 16,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [BITSIZE-1:0]         data,
    output logic [BITSIZE*NUM_W-1:0]   weights,
    output logic [BITSIZE*NUM_B-1:0]   bias
);

    always_ff @(posedge clk) begin
        if (rst) begin
            weights <= '0;
            bias    <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_W; i++) begin
                if (addr == ADDR_W'(i))
                    weights[i*BITSIZE +: BITSIZE] <= data;
            end
            for (int unsigned i = 0; i < NUM_B; i++) begin
                if (addr == ADDR_W'(NUM_W + i))
                    bias[i*BITSIZE +: BITSIZE] <= data;
            end
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: parameter load, pixel metering, line-buffer flush, stride gating, result counting.
module conv_frame_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned BITSIZE      = DEF_BITSIZE,
    parameter int unsigned IMAGE_SIZE   = DEF_IMAGE_SIZE,
    parameter int unsigned STRIDE       = DEF_STRIDE,
    parameter int unsigned NUM_W        = DEF_NUM_W,
    parameter int unsigned NUM_B        = DEF_NUM_B,
    parameter int unsigned FLUSH_PIXELS = DEF_FLUSH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reuse_params,
    input  logic                       param_valid,
    output logic                       param_ready,
    input  logic [BITSIZE-1:0]         param_data,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic                       fifo_wr_en,
    output logic                       pix_zero,
    input  logic                       win_valid,
    output logic                       conv_start,
    input  logic                       hs_valid,
    output logic [BITSIZE*NUM_W-1:0]   weights,
    output logic [BITSIZE*NUM_B-1:0]   bias,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned NPIX  = IMAGE_SIZE * IMAGE_SIZE;
    localparam int unsigned NOUT  = (IMAGE_SIZE / STRIDE) * (IMAGE_SIZE / STRIDE);
    localparam int unsigned NPAR  = NUM_W + NUM_B;
    localparam int unsigned PAR_W = cnt_w(NPAR);
    localparam int unsigned PIX_W = cnt_w(NPIX);
    localparam int unsigned FL_W  = cnt_w(FLUSH_PIXELS);
    localparam int unsigned POS_W = cnt_w(IMAGE_SIZE);
    localparam int unsigned OUT_W = cnt_w(NOUT + 1);

    state_t             state, state_nx;
    logic [PAR_W-1:0]   par_cnt;
    logic [PIX_W-1:0]   pix_cnt;
    logic [FL_W-1:0]    fl_cnt;
    logic [POS_W-1:0]   wrow, wcol;
    logic               win_full;
    logic [OUT_W-1:0]   out_cnt;
    logic               err_q;

    logic start_acc, par_acc, pix_acc, gate, win_acc, cnt_active, hs_acc, last_out, err_set;

    assign param_ready = (state == LOAD);
    assign pix_ready   = (state == STREAM);
    assign pix_zero    = (state == FLUSH);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign err         = err_q;

    assign start_acc  = (state == IDLE) && start;
    assign par_acc    = param_valid && param_ready;
    assign pix_acc    = pix_valid && pix_ready;
    assign fifo_wr_en = pix_acc || (state == FLUSH);

    assign gate       = state inside {STREAM, FLUSH, DRAIN};
    assign win_acc    = gate && win_valid && !win_full;
    assign conv_start = win_acc
                        && ((wrow % POS_W'(STRIDE)) == '0)
                        && ((wcol % POS_W'(STRIDE)) == '0);

    assign cnt_active = state inside {LOAD, STREAM, FLUSH, DRAIN};
    assign hs_acc     = cnt_active && hs_valid;
    assign last_out   = hs_acc && (out_cnt == OUT_W'(NOUT - 1));
    assign err_set    = ((state == IDLE) && hs_valid) || (gate && win_valid && win_full);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (start) state_nx = reuse_params ? STREAM : LOAD;
            LOAD:   if (par_acc && (par_cnt == PAR_W'(NPAR - 1))) state_nx = STREAM;
            STREAM: if (pix_acc && (pix_cnt == PIX_W'(NPIX - 1))) state_nx = FLUSH;
            FLUSH:  if (fl_cnt == FL_W'(FLUSH_PIXELS - 1)) state_nx = DRAIN;
            DRAIN:  state_nx = DRAIN;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // The final result ends the frame from any active state.
        if (last_out)
            state_nx = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            par_cnt  <= '0;
            pix_cnt  <= '0;
            fl_cnt   <= '0;
            wrow     <= '0;
            wcol     <= '0;
            win_full <= 1'b0;
            out_cnt  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                par_cnt  <= '0;
                pix_cnt  <= '0;
                fl_cnt   <= '0;
                wrow     <= '0;
                wcol     <= '0;
                win_full <= 1'b0;
                out_cnt  <= '0;
            end else begin
                if (par_acc)
                    par_cnt <= par_cnt + PAR_W'(1);
                if (pix_acc)
                    pix_cnt <= pix_cnt + PIX_W'(1);
                if (state == FLUSH)
                    fl_cnt <= fl_cnt + FL_W'(1);
                if (win_acc) begin
                    if (wcol == POS_W'(IMAGE_SIZE - 1)) begin
                        wcol <= '0;
                        if (wrow == POS_W'(IMAGE_SIZE - 1)) begin
                            wrow     <= '0;
                            win_full <= 1'b1;
                        end else begin
                            wrow <= wrow + POS_W'(1);
                        end
                    end else begin
                        wcol <= wcol + POS_W'(1);
                    end
                end
                if (hs_acc)
                    out_cnt <= out_cnt + OUT_W'(1);
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

    param_bank #(
        .BITSIZE (BITSIZE),
        .NUM_W   (NUM_W),
        .NUM_B   (NUM_B),
        .ADDR_W  (PAR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (par_acc),
        .addr    (par_cnt),
        .data    (param_data),
        .weights (weights),
        .bias    (bias)
    );

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl at IMAGE_SIZE=8 with an ideal line-buffer window stream.
module tb_conv_frame_ctrl;

    localparam int BS   = 18;
    localparam int IS   = 8;
    localparam int ST   = 2;
    localparam int NW   = 432;
    localparam int NB   = 16;
    localparam int FP   = 9;
    localparam int NPIX = IS * IS;
    localparam int NOUT = (IS / ST) * (IS / ST);
    localparam int NPAR = NW + NB;

    logic clk = 1'b0;
    logic rst, start, reuse_params, param_valid, pix_valid, win_valid, hs_valid;
    logic [BS-1:0] param_data;
    logic param_ready, pix_ready, fifo_wr_en, pix_zero, conv_start, busy, done, err;
    logic [BS*NW-1:0] weights;
    logic [BS*NB-1:0] bias;

    int checks = 0;
    int errors = 0;

    conv_frame_ctrl #(
        .BITSIZE      (BS),
        .IMAGE_SIZE   (IS),
        .STRIDE       (ST),
        .NUM_W        (NW),
        .NUM_B        (NB),
        .FLUSH_PIXELS (FP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reuse_params (reuse_params),
        .param_valid  (param_valid),
        .param_ready  (param_ready),
        .param_data   (param_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .fifo_wr_en   (fifo_wr_en),
        .pix_zero     (pix_zero),
        .win_valid    (win_valid),
        .conv_start   (conv_start),
        .hs_valid     (hs_valid),
        .weights      (weights),
        .bias         (bias),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [BS-1:0] wword(input int k);
        return weights[k*BS +: BS];
    endfunction

    function automatic logic [BS-1:0] bword(input int k);
        return bias[k*BS +: BS];
    endfunction

    task automatic drive_idle();
        start = 1'b0; reuse_params = 1'b0; param_valid = 1'b0; param_data = '0;
        pix_valid = 1'b0; win_valid = 1'b0; hs_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string pfx, input logic exp_err);
        check({pfx, "_param_ready"}, 64'(param_ready), 64'(0));
        check({pfx, "_pix_ready"},   64'(pix_ready),   64'(0));
        check({pfx, "_fifo_wr_en"},  64'(fifo_wr_en),  64'(0));
        check({pfx, "_pix_zero"},    64'(pix_zero),    64'(0));
        check({pfx, "_conv_start"},  64'(conv_start),  64'(0));
        check({pfx, "_busy"},        64'(busy),        64'(0));
        check({pfx, "_done"},        64'(done),        64'(0));
        check({pfx, "_err"},         64'(err),         64'(exp_err));
    endtask

    task automatic do_start(input logic reuse);
        @(negedge clk);
        start = 1'b1;
        reuse_params = reuse;
        @(negedge clk);
        start = 1'b0;
        reuse_params = 1'b0;
        #1;
        check("start_busy", 64'(busy), 64'(1));
        check("start_param_ready", 64'(param_ready), 64'(!reuse));
        check("start_pix_ready", 64'(pix_ready), 64'(reuse));
    endtask

    task automatic load_params();
        int k = 0;
        int cyc = 0;
        while (k < NPAR && cyc < 4000) begin
            @(negedge clk);
            param_valid = ($urandom_range(0, 2) != 0);
            param_data  = BS'(k + 1);
            #1;
            if (param_valid && param_ready) k++;
            cyc++;
        end
        @(negedge clk);
        param_valid = 1'b0;
        #1;
        check("load_count", 64'(k), 64'(NPAR));
        check("load_exit_param_ready", 64'(param_ready), 64'(0));
        check("load_exit_pix_ready", 64'(pix_ready), 64'(1));
        check("weight0", 64'(wword(0)), 64'(1));
        check("weight431", 64'(wword(NW - 1)), 64'(NW));
        check("bias0", 64'(bword(0)), 64'(NW + 1));
        check("bias15", 64'(bword(NB - 1)), 64'(NPAR));
    endtask

    // Runs a frame already in STREAM through to DONE and back to IDLE.
    task automatic run_frame(input bit gaps, input bit poke_start, input bit extra_win, input logic exp_err);
        int q[$];
        int cyc = 0, acc_pix = 0, win_sent = 0, hs_sent = 0;
        int n_wr = 0, n_zero = 0, n_cs = 0, n_zero_rdy = 0, cur;
        bit poked = 0, poke_chk = 0, extra_done = 0, finished = 0;
        while (!finished && cyc < 1500) begin
            @(negedge clk);
            drive_idle();
            if (hs_sent == NOUT) begin
                #1;
                check("done_pulse", 64'(done), 64'(1));
                check("done_busy", 64'(busy), 64'(1));
                check("frame_err", 64'(err), 64'(exp_err));
                @(negedge clk);
                #1;
                check("done_clear", 64'(done), 64'(0));
                check("idle_busy", 64'(busy), 64'(0));
                finished = 1;
            end else begin
                if (poke_chk) begin
                    poke_chk = 0;
                    #1;
                    check("start_ignored_pix_ready", 64'(pix_ready), 64'(1));
                end
                pix_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
                if (poke_start && !poked && acc_pix == 10) begin
                    start = 1'b1; poked = 1; poke_chk = 1;
                end
                if (win_sent < NPIX && cyc >= 2 && (cyc % 3) == 0)
                    win_valid = 1'b1;
                else if (extra_win && !extra_done && win_sent == NPIX && n_zero == FP)
                    win_valid = 1'b1;
                if (win_sent == NPIX && n_zero == FP && (extra_done || !extra_win)
                    && hs_sent < NOUT && (cyc % 2) == 0)
                    hs_valid = 1'b1;
                #1;
                if (fifo_wr_en) n_wr++;
                if (pix_zero) n_zero++;
                if (pix_zero && pix_ready) n_zero_rdy++;
                if (pix_valid && pix_ready) acc_pix++;
                cur = -1;
                if (win_valid && win_sent < NPIX) begin
                    cur = win_sent;
                    if (((win_sent / IS) % ST) == 0 && ((win_sent % IS) % ST) == 0)
                        q.push_back(win_sent);
                    win_sent++;
                end else if (win_valid) begin
                    check("extra_win_gated", 64'(conv_start), 64'(0));
                    extra_done = 1;
                end
                if (conv_start) begin
                    n_cs++;
                    if (q.size() == 0)
                        check("cs_unexpected", 64'(cur), 64'(-1));
                    else
                        check("cs_pos", 64'(cur), 64'(q.pop_front()));
                end
                if (hs_valid) hs_sent++;
            end
            cyc++;
        end
        check("frame_finished", 64'(finished), 64'(1));
        check("pix_accepted", 64'(acc_pix), 64'(NPIX));
        check("fifo_wr_count", 64'(n_wr), 64'(NPIX + FP));
        check("pix_zero_count", 64'(n_zero), 64'(FP));
        check("pix_zero_overlap", 64'(n_zero_rdy), 64'(0));
        check("conv_start_count", 64'(n_cs), 64'(NOUT));
        check("cs_missing", 64'(q.size()), 64'(0));
    endtask

    task automatic abort_frame();
        int acc = 0;
        int cyc = 0;
        do_start(1'b1);
        while (acc < 30 && cyc < 200) begin
            @(negedge clk);
            pix_valid = 1'b1;
            #1;
            if (pix_valid && pix_ready) acc++;
            cyc++;
        end
        check("abort_reach30", 64'(acc), 64'(30));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        check_quiet("abort", 1'b0);
        check("abort_weights", 64'(|weights), 64'(0));
        check("abort_bias", 64'(|bias), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        reset_dut();
        repeat (5) @(negedge clk);
        #1;
        check_quiet("reset", 1'b0);
        check("reset_weights", 64'(|weights), 64'(0));
        check("reset_bias", 64'(|bias), 64'(0));

        do_start(1'b0);
        repeat (4) @(negedge clk);
        #1;
        check("load_stall_param_ready", 64'(param_ready), 64'(1));
        check("load_stall_busy", 64'(busy), 64'(1));
        load_params();
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);

        do_start(1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("bank_held", 64'(bword(NB - 1)), 64'(NPAR));

        @(negedge clk);
        hs_valid = 1'b1;
        @(negedge clk);
        hs_valid = 1'b0;
        #1;
        check("idle_hs_err", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        #1;
        check("idle_hs_err_sticky", 64'(err), 64'(1));
        reset_dut();
        #1;
        check("err_cleared", 64'(err), 64'(0));

        do_start(1'b1);
        run_frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("extra_win_err_sticky", 64'(err), 64'(1));
        reset_dut();

        abort_frame();
        do_start(1'b0);
        load_params();
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
